// File: rtl/fetch_unit.sv
// Instruction fetch stage for the A64 core: owns the PC, issues strictly
// serialized requests to instruction memory and buffers up to two words for decode.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [63:0] id_pc
);

  typedef enum logic [1:0] {
    ST_REQ,
    ST_WAIT,
    ST_DRAIN
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [63:0] pc;
  logic [63:0] pc_next;
  logic [63:0] issued_addr;
  logic [31:0] fifo_inst [2];
  logic [63:0] fifo_pc   [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic        started;
  logic        req_fire;
  logic        push;
  logic        pop;

  // Redirect targets are word aligned; the low bits carry no information.
  logic        unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // started keeps the request line quiet until the first edge after reset.
  assign imem_req_valid = started && (state == ST_REQ) && (count < 2'd2);
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign id_valid = (count != 2'd0);
  assign id_inst  = fifo_inst[rd_ptr];
  assign id_pc    = fifo_pc[rd_ptr];

  // A redirect flushes everything, so it also suppresses the push and the pop.
  assign push = (state == ST_WAIT) && imem_resp_valid && !redirect_valid;
  assign pop  = id_valid && id_ready && !redirect_valid;

  always_comb begin
    state_next = state;
    pc_next    = pc;
    case (state)
      ST_REQ: begin
        if (req_fire) begin
          state_next = redirect_valid ? ST_DRAIN : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_resp_valid) begin
          state_next = ST_REQ;
        end else if (redirect_valid) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (imem_resp_valid) begin
          state_next = ST_REQ;
        end
      end
      default: state_next = ST_REQ;
    endcase

    if (redirect_valid) begin
      pc_next = {redirect_pc[63:2], 2'b00};
    end else if (push) begin
      pc_next = issued_addr + 64'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_REQ;
      pc           <= RESET_PC;
      issued_addr  <= RESET_PC;
      started      <= 1'b0;
      count        <= 2'd0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      fifo_inst[0] <= 32'd0;
      fifo_inst[1] <= 32'd0;
      fifo_pc[0]   <= 64'd0;
      fifo_pc[1]   <= 64'd0;
    end else begin
      started <= 1'b1;
      state   <= state_next;
      pc      <= pc_next;

      if (req_fire) begin
        issued_addr <= pc;
      end

      if (push) begin
        fifo_inst[wr_ptr] <= imem_resp_data;
        fifo_pc[wr_ptr]   <= issued_addr;
        wr_ptr            <= ~wr_ptr;
      end

      // On a flush the read pointer jumps to the write pointer so the queue is empty.
      if (redirect_valid) begin
        count  <= 2'd0;
        rd_ptr <= wr_ptr;
      end else begin
        if (pop) begin
          rd_ptr <= ~rd_ptr;
        end
        case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus randomized traffic, checked
// by a stream-level model whose expected deliveries are popped by a monitor.
module tb_fetch_unit;

  localparam logic [63:0] RESET_PC = 64'h1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [63:0] id_pc;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_inst        (id_inst),
    .id_pc          (id_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } item_t;

  int          checks = 0;
  int          failures = 0;
  item_t       exp_q[$];
  item_t       mon_item;
  logic [63:0] exp_fetch_pc;

  // Memory model controls and bookkeeping
  bit          mem_ready_rand = 1'b0;
  int          mem_lat_min = 0;
  int          mem_lat_max = 0;
  bit          mem_pending;
  bit          mem_outstanding;
  int          mem_wait;
  logic [63:0] mem_addr;
  bit          mem_accept;
  logic [63:0] mem_accept_addr;
  int          req_count;
  logic [63:0] req_log[$];

  function automatic logic [31:0] mem_word(input logic [63:0] addr);
    if (addr == 64'h1000) return 32'hD280_0020;
    return (addr[31:0] * 32'h9E37_79B1) ^ addr[63:32] ^ 32'h5A5A_0000;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit rv, input logic [63:0] rpc, input bit ir);
    redirect_valid = rv;
    redirect_pc    = rpc;
    id_ready       = ir;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  // Instruction memory: one outstanding request, response 1..N cycles after acceptance.
  initial begin
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'd0;
    mem_pending     = 1'b0;
    mem_outstanding = 1'b0;
    mem_wait        = 0;
    mem_addr        = 64'd0;
    req_count       = 0;
    forever begin
      @(negedge clk);
      mem_accept      = !rst && imem_req_valid && imem_req_ready;
      mem_accept_addr = imem_req_addr;
      @(posedge clk);
      #1;
      if (rst) begin
        mem_pending     = 1'b0;
        mem_outstanding = 1'b0;
        imem_resp_valid = 1'b0;
        imem_req_ready  = 1'b0;
      end else begin
        if (imem_resp_valid) begin
          imem_resp_valid = 1'b0;
          mem_outstanding = 1'b0;
        end
        if (mem_accept) begin
          mem_pending     = 1'b1;
          mem_outstanding = 1'b1;
          mem_addr        = mem_accept_addr;
          mem_wait        = $urandom_range(mem_lat_max, mem_lat_min);
          req_count++;
          req_log.push_back(mem_accept_addr);
        end
        if (mem_pending) begin
          if (mem_wait == 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(mem_addr);
            mem_pending     = 1'b0;
          end else begin
            mem_wait--;
          end
        end
        imem_req_ready = mem_ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // Reference model: the delivered stream is every accepted request since the last
  // redirect, in order, with the word memory holds at that address.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_fetch_pc = RESET_PC;
    end else begin
      if (mem_outstanding) begin
        checkOutput("single_outstanding", {63'd0, imem_req_valid}, 64'd0);
      end
      if (imem_req_valid && imem_req_ready) begin
        checkOutput("req_addr", imem_req_addr, exp_fetch_pc);
        exp_q.push_back('{pc: exp_fetch_pc, inst: mem_word(exp_fetch_pc)});
        exp_fetch_pc = exp_fetch_pc + 64'd4;
      end
      if (redirect_valid) begin
        exp_q.delete();
        exp_fetch_pc = redirect_pc & ~64'h3;
      end
    end
  end

  // Monitor: every instruction decode consumes must be the next expected one.
  always @(negedge clk) begin
    if (!rst && id_valid && id_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_pop: got pc %h expected no delivery", id_pc);
      end else begin
        mon_item = exp_q.pop_front();
        checkOutput("id_pc", id_pc, mon_item.pc);
        checkOutput("id_inst", {32'd0, id_inst}, {32'd0, mon_item.inst});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit found;
    int rc;

    rst = 1'b1;
    applyStimulus(1'b0, 64'd0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
    checkOutput("rst_id_valid", {63'd0, id_valid}, 64'd0);
    checkOutput("rst_id_inst", {32'd0, id_inst}, 64'd0);
    checkOutput("rst_id_pc", id_pc, 64'd0);
    checkOutput("rst_req_addr", imem_req_addr, RESET_PC);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset fetch and backpressure: two words buffered, then requests stop.
    $display("[TB] reset fetch / backpressure");
    repeat (12) nextCycle();
    checkOutput("bp_req_count", req_count, 2);
    checkOutput("bp_first_addr", req_log[0], 64'h1000);
    checkOutput("bp_second_addr", req_log[1], 64'h1004);
    checkOutput("bp_req_valid", {63'd0, imem_req_valid}, 64'd0);
    checkOutput("bp_id_valid", {63'd0, id_valid}, 64'd1);
    checkOutput("bp_id_pc", id_pc, 64'h1000);
    checkOutput("bp_id_inst", {32'd0, id_inst}, 64'hD280_0020);

    mem_lat_min = 2;
    mem_lat_max = 2;
    applyStimulus(1'b0, 64'd0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 64'd0, 1'b0);
    checkOutput("pop_id_pc", id_pc, 64'h1004);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      nextCycle();
      found = (req_count == 3);
    end
    checkOutput("pop_req_seen", {63'd0, found}, 64'd1);
    checkOutput("pop_req_addr", req_log[req_log.size() - 1], 64'h1008);

    // Redirect while the fetch of 0x1008 is outstanding.
    $display("[TB] redirect in WAIT");
    applyStimulus(1'b1, 64'h2003, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 64'd0, 1'b0);
    checkOutput("rw_id_valid", {63'd0, id_valid}, 64'd0);
    checkOutput("rw_req_valid", {63'd0, imem_req_valid}, 64'd0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      nextCycle();
      found = (req_count == 4);
    end
    checkOutput("rw_req_seen", {63'd0, found}, 64'd1);
    checkOutput("rw_req_addr", req_log[req_log.size() - 1], 64'h2000);
    applyStimulus(1'b0, 64'd0, 1'b1);
    found = id_valid;
    for (int i = 0; i < 10 && !found; i++) begin
      nextCycle();
      found = id_valid;
    end
    checkOutput("rw_id_seen", {63'd0, found}, 64'd1);
    checkOutput("rw_id_pc", id_pc, 64'h2000);
    checkOutput("rw_id_inst", {32'd0, id_inst}, {32'd0, mem_word(64'h2000)});

    // Redirect in the same cycle as a response: no drain cycle.
    $display("[TB] redirect coincident with response");
    mem_lat_min = 1;
    mem_lat_max = 1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      nextCycle();
      found = imem_resp_valid;
    end
    checkOutput("rc_resp_seen", {63'd0, found}, 64'd1);
    applyStimulus(1'b1, 64'h3000, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 64'd0, 1'b1);
    checkOutput("rc_req_valid", {63'd0, imem_req_valid}, 64'd1);
    checkOutput("rc_req_addr", imem_req_addr, 64'h3000);
    checkOutput("rc_id_valid", {63'd0, id_valid}, 64'd0);

    // Redirect during the request handshake: stale response must drain first.
    $display("[TB] redirect during handshake");
    mem_lat_min = 2;
    mem_lat_max = 2;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      nextCycle();
      found = imem_req_valid && imem_req_ready;
    end
    checkOutput("rh_hs_seen", {63'd0, found}, 64'd1);
    rc = req_count;
    applyStimulus(1'b1, 64'h4000, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 64'd0, 1'b1);
    checkOutput("rh_drain_req_valid", {63'd0, imem_req_valid}, 64'd0);
    found = imem_resp_valid;
    for (int i = 0; i < 10 && !found; i++) begin
      nextCycle();
      found = imem_resp_valid;
    end
    checkOutput("rh_stale_resp_seen", {63'd0, found}, 64'd1);
    nextCycle();
    checkOutput("rh_req_valid", {63'd0, imem_req_valid}, 64'd1);
    checkOutput("rh_req_addr", imem_req_addr, 64'h4000);
    checkOutput("rh_req_count", req_count, rc + 1);

    // PC wrap at the top of the address space.
    $display("[TB] pc wrap");
    mem_lat_min = 0;
    mem_lat_max = 0;
    applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 64'd0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      nextCycle();
      found = (req_log[req_log.size() - 1] == 64'hFFFF_FFFF_FFFF_FFFC);
    end
    checkOutput("wrap_top_seen", {63'd0, found}, 64'd1);
    rc = req_count;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      nextCycle();
      found = (req_count > rc);
    end
    checkOutput("wrap_next_seen", {63'd0, found}, 64'd1);
    checkOutput("wrap_addr", req_log[req_log.size() - 1], 64'h0);

    // Randomized traffic: stalls, variable latency, random redirects.
    $display("[TB] random traffic");
    mem_ready_rand = 1'b1;
    mem_lat_min    = 0;
    mem_lat_max    = 2;
    for (int i = 0; i < 3000; i++) begin
      nextCycle();
      applyStimulus(($urandom_range(0, 19) == 0), {$urandom, $urandom},
                    ($urandom_range(0, 2) != 0));
    end

    // Stop decode: exactly two words must be buffered, none lost or invented.
    nextCycle();
    applyStimulus(1'b0, 64'd0, 1'b0);
    mem_ready_rand = 1'b0;
    repeat (20) nextCycle();
    checkOutput("final_backlog", exp_q.size(), 64'd2);
    checkOutput("final_id_valid", {63'd0, id_valid}, 64'd1);
    checkOutput("final_req_valid", {63'd0, imem_req_valid}, 64'd0);
    applyStimulus(1'b0, 64'd0, 1'b1);
    repeat (20) nextCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
